// File: rtl/dmem_byte_lane_resp.sv
// dmem_byte_lane_resp
//   Memory end of the CPU load/store interface (LW/LB/SW/SB).
//   Two 8-bit banks (hi = even byte, lo = odd byte, big-endian) behind a
//   valid/ready request channel and a registered one-deep response channel.
//   Optional feature macro: DMEM_WBUF_EN adds a one-entry posted write buffer
//   in front of single-port banks, with per-lane load forwarding.
//   Bank contents power up undefined and are never reset.
module dmem_byte_lane_resp #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic        i_req_byte,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [15:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  // Full 15-bit word index is compared, so aliases above the bank array are errors.
  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Banks
  logic [7:0]    mem_h_q [DEPTH];
  logic [7:0]    mem_l_q [DEPTH];

  // Response state
  state_t        state_q, state_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  // Request decode
  logic [AW-1:0] req_idx_s;
  logic          req_lane_s;
  logic          req_oor_s;
  logic          base_ready_s;
  logic          stall_s;
  logic          req_ready_s;
  logic          accept_s;
  logic          consume_s;

  // Bank read/write paths
  logic [7:0]    rd_h_s, rd_l_s;
  logic [7:0]    ld_h_s, ld_l_s;
  logic [15:0]   load_data_s;
  logic [AW-1:0] bank_idx_s;
  logic          bank_we_h_s, bank_we_l_s;
  logic [7:0]    bank_wd_h_s, bank_wd_l_s;

  // Address decode and handshake terms
  always_comb begin
    req_idx_s    = i_req_addr[AW:1];
    req_lane_s   = i_req_addr[0];
    req_oor_s    = ({1'b0, i_req_addr[15:1]} >= DEPTH_W);
    base_ready_s = ~rsp_valid_q | i_rsp_ready;
    req_ready_s  = base_ready_s & ~stall_s;
    accept_s     = i_req_valid & req_ready_s & ~i_rst;
    consume_s    = rsp_valid_q & i_rsp_ready;
  end

  // Asynchronous bank read at the request index; out-of-range reads return zero
  always_comb begin
    if (req_oor_s) begin
      rd_h_s = 8'h00;
      rd_l_s = 8'h00;
    end else begin
      rd_h_s = mem_h_q[req_idx_s];
      rd_l_s = mem_l_q[req_idx_s];
    end
  end

`ifdef DMEM_WBUF_EN
  // Posted write buffer: one word, with a per-lane byte mask (bit1 = hi, bit0 = lo)
  logic          wb_valid_q, wb_valid_d;
  logic [AW-1:0] wb_idx_q, wb_idx_d;
  logic [15:0]   wb_data_q, wb_data_d;
  logic [1:0]    wb_mask_q, wb_mask_d;
  logic          wb_hit_s;
  logic          store_acc_s;
  logic          drain_s;

  // Buffer hit, stall and drain decisions
  always_comb begin
    wb_hit_s    = wb_valid_q & (wb_idx_q == req_idx_s) & ~req_oor_s;
    // An SB into the buffered word merges; any other in-range store must wait for a drain.
    stall_s     = i_req_valid & i_req_we & ~req_oor_s & wb_valid_q & ~(i_req_byte & wb_hit_s);
    store_acc_s = accept_s & i_req_we & ~req_oor_s;
    drain_s     = wb_valid_q & ~accept_s & ~i_rst;
  end

  // Per-lane forwarding of buffered bytes into load data
  always_comb begin
    if (wb_hit_s & wb_mask_q[1]) begin
      ld_h_s = wb_data_q[15:8];
    end else begin
      ld_h_s = rd_h_s;
    end
    if (wb_hit_s & wb_mask_q[0]) begin
      ld_l_s = wb_data_q[7:0];
    end else begin
      ld_l_s = rd_l_s;
    end
  end

  // Next buffer contents: drain on idle cycles, capture or merge accepted stores
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_idx_d   = wb_idx_q;
    wb_data_d  = wb_data_q;
    wb_mask_d  = wb_mask_q;
    if (drain_s) begin
      wb_valid_d = 1'b0;
      wb_mask_d  = 2'b00;
    end else if (store_acc_s) begin
      if (wb_valid_q) begin
        // Only an SB to the buffered word can be accepted while the buffer is valid.
        if (req_lane_s) begin
          wb_data_d[7:0] = i_req_wdata[7:0];
          wb_mask_d[0]   = 1'b1;
        end else begin
          wb_data_d[15:8] = i_req_wdata[7:0];
          wb_mask_d[1]    = 1'b1;
        end
      end else begin
        wb_valid_d = 1'b1;
        wb_idx_d   = req_idx_s;
        if (i_req_byte) begin
          if (req_lane_s) begin
            wb_data_d = {8'h00, i_req_wdata[7:0]};
            wb_mask_d = 2'b01;
          end else begin
            wb_data_d = {i_req_wdata[7:0], 8'h00};
            wb_mask_d = 2'b10;
          end
        end else begin
          wb_data_d = i_req_wdata;
          wb_mask_d = 2'b11;
        end
      end
    end else begin
      wb_valid_d = wb_valid_q;
    end
  end

  // Buffer registers; reset drops any un-drained entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_data_q  <= 16'h0000;
      wb_mask_q  <= 2'b00;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_idx_q   <= wb_idx_d;
      wb_data_q  <= wb_data_d;
      wb_mask_q  <= wb_mask_d;
    end
  end

  // Bank write port is owned by the drain path
  always_comb begin
    bank_idx_s  = wb_idx_q;
    bank_we_h_s = drain_s & wb_mask_q[1];
    bank_we_l_s = drain_s & wb_mask_q[0];
    bank_wd_h_s = wb_data_q[15:8];
    bank_wd_l_s = wb_data_q[7:0];
  end
`else
  // Stores go straight to the banks on the accept edge
  always_comb begin
    stall_s     = 1'b0;
    ld_h_s      = rd_h_s;
    ld_l_s      = rd_l_s;
    bank_idx_s  = req_idx_s;
    bank_we_h_s = accept_s & i_req_we & ~req_oor_s & (~i_req_byte | ~req_lane_s);
    bank_we_l_s = accept_s & i_req_we & ~req_oor_s & (~i_req_byte | req_lane_s);
    if (i_req_byte) begin
      bank_wd_h_s = i_req_wdata[7:0];
    end else begin
      bank_wd_h_s = i_req_wdata[15:8];
    end
    bank_wd_l_s = i_req_wdata[7:0];
  end
`endif

  // Lane steering and zero-extension of load data
  always_comb begin
    if (i_req_byte) begin
      if (req_lane_s) begin
        load_data_s = {8'h00, ld_l_s};
      end else begin
        load_data_s = {8'h00, ld_h_s};
      end
    end else begin
      load_data_s = {ld_h_s, ld_l_s};
    end
  end

  // Bank write (contents intentionally not reset)
  always_ff @(posedge i_clk) begin
    if (bank_we_h_s) begin
      mem_h_q[bank_idx_s] <= bank_wd_h_s;
    end
    if (bank_we_l_s) begin
      mem_l_q[bank_idx_s] <= bank_wd_l_s;
    end
  end

  // Response FSM next state and response payload
  always_comb begin
    state_d     = state_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s) begin
          state_d = ST_FULL;
        end else if (consume_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    if (accept_s) begin
      rsp_err_d = req_oor_s;
      if (req_oor_s | i_req_we) begin
        rsp_rdata_d = 16'h0000;
      end else begin
        rsp_rdata_d = load_data_s;
      end
    end else begin
      rsp_err_d = rsp_err_q;
    end
    rsp_valid_d = (state_d == ST_FULL);
  end

  // Response registers; reset drops any pending response
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_EMPTY;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign o_req_ready = req_ready_s;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_err   = rsp_err_q;

endmodule
